// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button debounce bank.
// Defaults target the 100 MHz board clock.
package btn_pkg;

   localparam int SYNC_STAGES          = 2;
   localparam int CLK_HZ               = 100_000_000;
   localparam int DEF_DEBOUNCE_CYCLES  = 10_000_000;
   localparam int DEF_REPEAT_DELAY     = CLK_HZ / 2;
   localparam int DEF_REPEAT_PERIOD    = CLK_HZ / 10;

   // Counter width for values 0..x-1, never narrower than one bit.
   function automatic int clog2_min1(input int x);
      return (x < 2) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-FF synchroniser, symmetric stability filter,
// registered press/release pulses and optional hold-to-repeat.
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat
);

   localparam int               CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s2;
   logic [CNT_W-1:0]       cnt;
   logic                   flip;

   assign s2   = sync[SYNC_STAGES-1];
   assign flip = (s2 != btn_level) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync        <= '0;
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         sync        <= {sync[SYNC_STAGES-2:0], btn_in};
         btn_press   <= flip & ~btn_level;
         btn_release <= flip & btn_level;
         // Any sample matching the current level restarts the filter.
         if ((s2 == btn_level) || flip) cnt <= '0;
         else                           cnt <= cnt + 1'b1;
         if (flip) btn_level <= ~btn_level;
      end
   end

   if (REPEAT_EN != 0) begin : g_rep
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = clog2_min1(RMAX);

      logic [RW-1:0] rcnt;
      logic [RW-1:0] rlast;
      logic          first;

      // First pulse waits the long delay, later ones the short period.
      assign rlast = first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rcnt       <= '0;
            first      <= 1'b0;
            btn_repeat <= 1'b0;
         end else if (flip) begin
            rcnt       <= '0;
            first      <= 1'b1;
            btn_repeat <= 1'b0;
         end else if (btn_level) begin
            if (rcnt == rlast) begin
               rcnt       <= '0;
               first      <= 1'b0;
               btn_repeat <= 1'b1;
            end else begin
               rcnt       <= rcnt + 1'b1;
               btn_repeat <= 1'b0;
            end
         end else begin
            rcnt       <= '0;
            btn_repeat <= 1'b0;
         end
      end
   end else begin : g_norep
      assign btn_repeat = 1'b0;
   end

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of NUM_BTN independent button debouncers between board pins and
// the user control FSMs.
module btn_debounce_bank
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_repeat
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .btn_in      (btn_in[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_repeat  (btn_repeat[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Bench for btn_debounce_bank: directed scenarios plus random pin activity,
// checked every cycle against a sliding-window / arithmetic reference.
module tb_btn_debounce_bank;

   localparam int NB = 2;
   localparam int DC = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NB-1:0] btn_in = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

   btn_debounce_bank #(
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   // reference state
   logic [NB-1:0] lvl_m = '0;
   logic [NB-1:0] d1 = '0, d2 = '0;
   bit            win [NB][$];
   int            press_e [NB];

   // observations for directed checks
   int obs_press [NB];
   int obs_rel   [NB];
   int rpt_cnt   [NB];

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      lvl_m = '0; d1 = '0; d2 = '0;
      for (int c = 0; c < NB; c++) begin
         win[c].delete();
         press_e[c] = -1000;
      end
   endtask

   // Drive pins after the current edge, advance one edge, update model, check.
   task automatic step(input logic [NB-1:0] pins);
      logic [NB-1:0] ep, er, ert;
      btn_in = pins;
      @(posedge clk);
      edge_n++;
      for (int c = 0; c < NB; c++) begin
         bit s2p, all_diff;
         int k;
         s2p   = d2[c];
         d2[c] = d1[c];
         d1[c] = pins[c];
         win[c].push_back(s2p);
         if (win[c].size() > DC) void'(win[c].pop_front());
         // level flips once the last DC synchronised samples all disagree with it
         all_diff = (win[c].size() == DC);
         for (int i = 0; i < win[c].size(); i++)
            if (win[c][i] == lvl_m[c]) all_diff = 1'b0;
         ep[c] = all_diff && !lvl_m[c];
         er[c] = all_diff && lvl_m[c];
         if (all_diff) lvl_m[c] = ~lvl_m[c];
         if (ep[c]) press_e[c] = edge_n;
         k = edge_n - press_e[c];
         ert[c] = lvl_m[c] && !ep[c] && (k >= RD) && (((k - RD) % RP) == 0);
      end
      #1;
      chk("level",   btn_level,   lvl_m);
      chk("press",   btn_press,   ep);
      chk("release", btn_release, er);
      chk("repeat",  btn_repeat,  ert);
      for (int c = 0; c < NB; c++) begin
         if (btn_press[c])   obs_press[c] = edge_n;
         if (btn_release[c]) obs_rel[c]   = edge_n;
         if (btn_repeat[c])  rpt_cnt[c]++;
      end
   endtask

   task automatic steps(input logic [NB-1:0] pins, input int n);
      for (int i = 0; i < n; i++) step(pins);
   endtask

   // Asynchronous reset between edges; outputs must drop at once.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_level",   btn_level,   '0);
      chk("rst_press",   btn_press,   '0);
      chk("rst_release", btn_release, '0);
      chk("rst_repeat",  btn_repeat,  '0);
      repeat (2) begin
         @(posedge clk);
         edge_n++;
      end
      #1;
      reset_n = 1'b1;
      model_clear();
   endtask

   initial begin
      int n0, s0, d0, r0;
      logic [NB-1:0] cur;
      model_clear();
      for (int c = 0; c < NB; c++) begin
         obs_press[c] = -1; obs_rel[c] = -1; rpt_cnt[c] = 0;
      end

      // reset state at a clock edge
      @(posedge clk);
      #1;
      chk("init_level",   btn_level,   '0);
      chk("init_press",   btn_press,   '0);
      chk("init_release", btn_release, '0);
      chk("init_repeat",  btn_repeat,  '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      steps(2'b00, 3);

      // clean press, then 30-cycle hold with auto-repeat
      n0 = edge_n;
      steps(2'b01, 6);
      chk_int("press_lat", obs_press[0], n0 + 6);
      steps(2'b01, 30);
      chk_int("repeat_cnt30", rpt_cnt[0], 7);

      // clean release
      d0 = edge_n;
      steps(2'b00, 10);
      chk_int("release_lat", obs_rel[0], d0 + 6);

      // bounce before settling high
      step(2'b01); step(2'b00); step(2'b01); step(2'b00);
      n0 = edge_n;
      steps(2'b01, 10);
      chk_int("bounce_press", obs_press[0], n0 + 6);
      steps(2'b00, 8);

      // both press together; channel 1 releases while channel 0 repeats
      for (int c = 0; c < NB; c++) rpt_cnt[c] = 0;
      s0 = edge_n;
      steps(2'b11, 16);
      chk_int("sim_press0", obs_press[0], s0 + 6);
      chk_int("sim_press1", obs_press[1], s0 + 6);
      d0 = edge_n;
      steps(2'b01, 10);
      chk_int("sim_rel1", obs_rel[1], d0 + 6);
      chk_int("sim_rpt1", rpt_cnt[1], 2);
      chk_int("sim_rpt0", rpt_cnt[0], 4);
      steps(2'b00, 8);

      // reset mid-hold while pins stay high
      n0 = edge_n;
      steps(2'b11, 11);
      chk_int("pre_rst_press", obs_press[0], n0 + 6);
      do_reset();
      r0 = edge_n;
      steps(2'b11, 8);
      chk_int("rst_repress0", obs_press[0], r0 + 6);
      chk_int("rst_repress1", obs_press[1], r0 + 6);
      steps(2'b00, 8);

      // random pin activity with occasional long holds
      cur = '0;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < NB; c++)
            if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
         if (i == 300) do_reset();
         step(cur);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
